// File: rtl/ddr3_arb_pkg.sv
// Shared types and MIG command encodings for the DDR3 port arbiter.
package ddr3_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WDATA = 2'd1,
        ST_CMD   = 2'd2,
        ST_RWAIT = 2'd3
    } arb_state_e;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the search starts one past the last winner
// and wraps, so a port that just won is considered last.
module rr_arbiter #(
    parameter int NUM_PORTS = 3,
    parameter int IDX_W     = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     last_grant,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 grant_valid
);

    always_comb begin
        int cand;
        cand        = 0;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = (int'(last_grant) + i) % NUM_PORTS;
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/ddr3_port_arbiter.sv
// Shares one MIG app interface between several requesters, one transaction
// at a time, with round-robin fairness and per-port read-data steering.
module ddr3_port_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 27,
    parameter int DATA_W    = 128
) (
    input  logic                                clk,
    input  logic                                sys_rst,
    input  logic                                init_calib_complete,
    input  logic [NUM_PORTS-1:0]                req_valid,
    input  logic [NUM_PORTS-1:0]                req_we,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0]    req_addr,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0]    req_wdata,
    input  logic [NUM_PORTS-1:0][DATA_W/8-1:0]  req_wmask,
    output logic [NUM_PORTS-1:0]                req_ready,
    output logic [NUM_PORTS-1:0]                rsp_valid,
    output logic [DATA_W-1:0]                   rsp_rdata,
    output logic                                app_en,
    output logic [2:0]                          app_cmd,
    output logic [ADDR_W-1:0]                   app_addr,
    input  logic                                app_rdy,
    output logic                                app_wdf_wren,
    output logic                                app_wdf_end,
    output logic [DATA_W-1:0]                   app_wdf_data,
    output logic [DATA_W/8-1:0]                 app_wdf_mask,
    input  logic                                app_wdf_rdy,
    input  logic [DATA_W-1:0]                   app_rd_data,
    input  logic                                app_rd_data_valid,
    output logic                                busy,
    output arb_state_e                          state_dbg
);

    localparam int IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int MASK_W = DATA_W / 8;

    arb_state_e              state, state_nx;
    logic [IDX_W-1:0]        last_grant, owner;
    logic                    lat_we;
    logic [ADDR_W-1:0]       lat_addr;
    logic [DATA_W-1:0]       lat_wdata;
    logic [MASK_W-1:0]       lat_wmask;
    logic [NUM_PORTS-1:0]    grant;
    logic [IDX_W-1:0]        grant_idx;
    logic                    grant_valid;
    logic                    accept;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_rr (
        .req         (req_valid),
        .last_grant  (last_grant),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Handshakes: a transfer happens on the rising edge where valid/en and
    // ready/rdy are both high; the driving side holds its payload until then.
    assign accept = (state == ST_IDLE) && init_calib_complete && grant_valid && !sys_rst;

    always_comb begin
        state_nx     = state;
        req_ready    = '0;
        app_en       = 1'b0;
        app_cmd      = 3'b000;
        app_addr     = '0;
        app_wdf_wren = 1'b0;
        app_wdf_end  = 1'b0;
        app_wdf_data = '0;
        app_wdf_mask = '0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    req_ready = grant;
                    state_nx  = req_we[grant_idx] ? ST_WDATA : ST_CMD;
                end
            end
            ST_WDATA: begin
                app_wdf_wren = 1'b1;
                app_wdf_end  = 1'b1;
                app_wdf_data = lat_wdata;
                app_wdf_mask = lat_wmask;
                if (app_wdf_rdy) state_nx = ST_CMD;
            end
            ST_CMD: begin
                app_en   = 1'b1;
                app_cmd  = lat_we ? CMD_WRITE : CMD_READ;
                // A BL8 burst is always column-aligned.
                app_addr = {lat_addr[ADDR_W-1:3], 3'b000};
                if (app_rdy) state_nx = lat_we ? ST_IDLE : ST_RWAIT;
            end
            ST_RWAIT: begin
                if (app_rd_data_valid) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state      <= ST_IDLE;
            last_grant <= IDX_W'(NUM_PORTS - 1);
            owner      <= '0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_wmask  <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
        end else begin
            state     <= state_nx;
            rsp_valid <= '0;
            if (accept) begin
                last_grant <= grant_idx;
                owner      <= grant_idx;
                lat_we     <= req_we[grant_idx];
                lat_addr   <= req_addr[grant_idx];
                lat_wdata  <= req_wdata[grant_idx];
                lat_wmask  <= req_wmask[grant_idx];
            end
            if (state == ST_RWAIT && app_rd_data_valid) begin
                rsp_rdata <= app_rd_data;
                rsp_valid <= NUM_PORTS'(1) << owner;
            end
        end
    end

    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Randomized and directed checks of ddr3_port_arbiter against a transaction-level
// model: round-robin grant prediction, expected MIG command queue, read steering.
module tb_ddr3_port_arbiter;
    import ddr3_arb_pkg::*;

    localparam int NP = 3;
    localparam int AW = 27;
    localparam int DW = 128;
    localparam int MW = DW / 8;

    logic                    clk = 1'b0;
    logic                    sys_rst;
    logic                    init_calib_complete;
    logic [NP-1:0]           req_valid;
    logic [NP-1:0]           req_we;
    logic [NP-1:0][AW-1:0]   req_addr;
    logic [NP-1:0][DW-1:0]   req_wdata;
    logic [NP-1:0][MW-1:0]   req_wmask;
    logic [NP-1:0]           req_ready;
    logic [NP-1:0]           rsp_valid;
    logic [DW-1:0]           rsp_rdata;
    logic                    app_en;
    logic [2:0]              app_cmd;
    logic [AW-1:0]           app_addr;
    logic                    app_rdy;
    logic                    app_wdf_wren;
    logic                    app_wdf_end;
    logic [DW-1:0]           app_wdf_data;
    logic [MW-1:0]           app_wdf_mask;
    logic                    app_wdf_rdy;
    logic [DW-1:0]           app_rd_data;
    logic                    app_rd_data_valid;
    logic                    busy;
    arb_state_e              state_dbg;

    always #5 clk = ~clk;

    ddr3_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk                 (clk),
        .sys_rst             (sys_rst),
        .init_calib_complete (init_calib_complete),
        .req_valid           (req_valid),
        .req_we              (req_we),
        .req_addr            (req_addr),
        .req_wdata           (req_wdata),
        .req_wmask           (req_wmask),
        .req_ready           (req_ready),
        .rsp_valid           (rsp_valid),
        .rsp_rdata           (rsp_rdata),
        .app_en              (app_en),
        .app_cmd             (app_cmd),
        .app_addr            (app_addr),
        .app_rdy             (app_rdy),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_mask        (app_wdf_mask),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_rd_data         (app_rd_data),
        .app_rd_data_valid   (app_rd_data_valid),
        .busy                (busy),
        .state_dbg           (state_dbg)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [MW-1:0] mask;
        int            port;
    } txn_t;

    // Reference model: accepted transactions awaiting the MIG, in order.
    txn_t          exp_q[$];
    int            grant_q[$];
    int            m_last;
    bit            m_busy;
    bit            wd_done;
    bit            rd_wait;
    int            rd_port;
    int            rd_cnt;
    bit            rsp_due;
    int            rsp_port;
    logic [DW-1:0] rsp_data;
    logic [NP-1:0] accepted;
    int            busy_cnt;
    bit            hang;
    int            cnt_wren, cnt_en, cnt_rdy, n_done;
    int            n_vec, n_err;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic finish_report();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_busy   = 1'b0;
        m_last   = NP - 1;
        wd_done  = 1'b0;
        rd_wait  = 1'b0;
        rsp_due  = 1'b0;
        accepted = '0;
        busy_cnt = 0;
    endtask

    task automatic evaluate();
        logic [NP-1:0] exp_rdy;
        logic [NP-1:0] exp_rsp;
        bit            busy_now, has_front, exp_wren, exp_en;
        txn_t          f;
        f = '{we: 1'b0, addr: '0, data: '0, mask: '0, port: 0};
        exp_rsp = rsp_due ? (NP'(1) << rsp_port) : '0;
        check_eq("rsp_valid", rsp_valid, exp_rsp);
        if (rsp_due) check_eq("rsp_rdata", rsp_rdata, rsp_data);
        rsp_due = 1'b0;
        if (sys_rst) begin
            model_reset();
            return;
        end
        busy_now = m_busy;
        check_eq("busy", busy, busy_now);
        if (app_wdf_wren) cnt_wren++;
        if (app_en) cnt_en++;
        if (|req_ready) cnt_rdy++;

        has_front = exp_q.size() > 0;
        if (has_front) f = exp_q[0];
        exp_wren = has_front && f.we && !wd_done;
        exp_en   = has_front && (!f.we || wd_done);
        check_eq("wdf_wren", app_wdf_wren, exp_wren);
        if (app_wdf_wren && exp_wren) begin
            check_eq("wdf_end", app_wdf_end, 1'b1);
            check_eq("wdf_data", app_wdf_data, f.data);
            check_eq("wdf_mask", app_wdf_mask, f.mask);
        end
        check_eq("app_en", app_en, exp_en);
        if (app_en && exp_en) begin
            check_eq("app_cmd", app_cmd, f.we ? 3'b000 : 3'b001);
            check_eq("app_addr", app_addr, {f.addr[AW-1:3], 3'b000});
        end
        if (exp_wren && app_wdf_rdy) wd_done = 1'b1;

        if (rd_wait && app_rd_data_valid) begin
            rsp_due  = 1'b1;
            rsp_port = rd_port;
            rsp_data = app_rd_data;
            rd_wait  = 1'b0;
            m_busy   = 1'b0;
            n_done++;
        end
        if (exp_en && app_rdy) begin
            void'(exp_q.pop_front());
            if (f.we) begin
                m_busy = 1'b0;
                n_done++;
            end else begin
                rd_wait = 1'b1;
                rd_port = f.port;
                rd_cnt  = $urandom_range(1, 5);
            end
        end

        // Round robin: first requester after the previous winner, wrapping.
        exp_rdy = '0;
        if (!busy_now && init_calib_complete) begin
            for (int i = 1; i <= NP; i++) begin
                int p;
                p = (m_last + i) % NP;
                if (exp_rdy == '0 && req_valid[p]) exp_rdy[p] = 1'b1;
            end
        end
        check_eq("req_ready", req_ready, exp_rdy);
        for (int g = 0; g < NP; g++) begin
            if (exp_rdy[g]) begin
                exp_q.push_back('{we: req_we[g], addr: req_addr[g], data: req_wdata[g],
                                  mask: req_wmask[g], port: g});
                grant_q.push_back(g);
                m_last      = g;
                m_busy      = 1'b1;
                wd_done     = 1'b0;
                accepted[g] = 1'b1;
            end
        end

        busy_cnt = m_busy ? busy_cnt + 1 : 0;
        if (busy_cnt > 200) begin
            check_eq("watchdog", busy_cnt, 0);
            hang = 1'b1;
        end
    endtask

    task automatic step();
        @(negedge clk);
        evaluate();
        if (hang) finish_report();
        @(posedge clk);
        #1;
    endtask

    task automatic new_request(input int p);
        req_we[p]    = 1'($urandom_range(0, 1));
        req_addr[p]  = AW'($urandom);
        req_wdata[p] = {$urandom, $urandom, $urandom, $urandom};
        req_wmask[p] = MW'($urandom);
        req_valid[p] = 1'b1;
    endtask

    task automatic drive_return();
        app_rd_data = {$urandom, $urandom, $urandom, $urandom};
        if (rd_wait) begin
            if (rd_cnt > 1) begin
                rd_cnt--;
                app_rd_data_valid = 1'b0;
            end else begin
                app_rd_data_valid = 1'b1;
            end
        end else begin
            app_rd_data_valid = ($urandom_range(0, 7) == 0);
        end
    endtask

    task automatic drive_random(input bit persist, input bit full_rdy);
        for (int p = 0; p < NP; p++) begin
            if (accepted[p]) begin
                accepted[p] = 1'b0;
                if (persist) new_request(p);
                else req_valid[p] = 1'b0;
            end else if (!req_valid[p]) begin
                if (persist || $urandom_range(0, 2) == 0) new_request(p);
            end else if (!persist && $urandom_range(0, 19) == 0) begin
                req_valid[p] = 1'b0;
            end
        end
        app_rdy     = full_rdy || ($urandom_range(0, 3) != 0);
        app_wdf_rdy = full_rdy || ($urandom_range(0, 3) != 0);
        drive_return();
    endtask

    task automatic drain();
        req_valid = '0;
        accepted  = '0;
        init_calib_complete = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (!m_busy && exp_q.size() == 0) break;
            app_rdy     = 1'b1;
            app_wdf_rdy = 1'b1;
            drive_return();
            step();
        end
        app_rd_data_valid = 1'b0;
        step();
        check_eq("drained", m_busy, 1'b0);
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        req_valid = '0;
        app_rd_data_valid = 1'b0;
        step();
        sys_rst = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_err = 0; hang = 1'b0; n_done = 0;
        cnt_wren = 0; cnt_en = 0; cnt_rdy = 0;
        model_reset();
        sys_rst = 1'b1;
        init_calib_complete = 1'b1;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wmask = '0;
        app_rdy = 1'b0; app_wdf_rdy = 1'b0; app_rd_data = '0; app_rd_data_valid = 1'b0;
        step();
        step();
        sys_rst = 1'b0;
        step();
        check_eq("rst_state", state_dbg, ST_IDLE);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_app_en", app_en, 1'b0);
        check_eq("rst_wren", app_wdf_wren, 1'b0);

        // Port 1 read, unaligned address, A5 read data.
        req_we[1] = 1'b0;
        req_addr[1] = 27'h0000123;
        req_valid = 3'b010;
        app_rdy = 1'b1;
        step();
        req_valid = '0; accepted = '0;
        check_eq("t1_addr", app_addr, 27'h0000120);
        check_eq("t1_cmd", app_cmd, 3'b001);
        step();
        app_rd_data_valid = 1'b1;
        app_rd_data = {16{8'hA5}};
        step();
        app_rd_data_valid = 1'b0;
        check_eq("t1_rsp_valid", rsp_valid, 3'b010);
        check_eq("t1_rsp_rdata", rsp_rdata, {16{8'hA5}});
        step();

        // All ports requesting continuously from reset.
        do_reset();
        grant_q.delete();
        for (int i = 0; i < 300; i++) begin
            if (grant_q.size() >= 6) break;
            drive_random(1'b1, 1'b1);
            step();
        end
        check_eq("t2_ngrants", grant_q.size() >= 6, 1'b1);
        for (int i = 0; i < 6; i++)
            check_eq("t2_grant_order", (i < grant_q.size()) ? grant_q[i] : -1, i % 3);
        drain();

        // Port 2 write with back-pressure on both MIG channels.
        do_reset();
        req_we[2] = 1'b1;
        req_addr[2] = AW'($urandom);
        req_wdata[2] = {$urandom, $urandom, $urandom, $urandom};
        req_wmask[2] = MW'($urandom);
        req_valid = 3'b100;
        app_wdf_rdy = 1'b0;
        app_rdy = 1'b0;
        step();
        req_valid = '0; accepted = '0;
        cnt_wren = 0; cnt_en = 0;
        for (int i = 0; i < 4; i++) step();
        app_wdf_rdy = 1'b1;
        step();
        app_wdf_rdy = 1'b0;
        step();
        step();
        app_rdy = 1'b1;
        step();
        app_rdy = 1'b0;
        step();
        check_eq("t3_wren_cycles", cnt_wren, 5);
        check_eq("t3_en_cycles", cnt_en, 3);

        // Calibration low blocks grants; port 0 wins when it rises.
        do_reset();
        init_calib_complete = 1'b0;
        for (int p = 0; p < NP; p++) new_request(p);
        cnt_rdy = 0;
        for (int i = 0; i < 20; i++) step();
        check_eq("t4_no_ready", cnt_rdy, 0);
        grant_q.delete();
        init_calib_complete = 1'b1;
        step();
        check_eq("t4_first_grant", (grant_q.size() > 0) ? grant_q[0] : -1, 0);
        drain();

        // Reset during a read wait, then a stray read return.
        do_reset();
        req_we[1] = 1'b0;
        req_addr[1] = AW'($urandom);
        req_valid = 3'b010;
        app_rdy = 1'b1;
        step();
        req_valid = '0; accepted = '0;
        step();
        app_rdy = 1'b0;
        step();
        check_eq("t5_in_rwait", state_dbg, ST_RWAIT);
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        app_rd_data_valid = 1'b1;
        app_rd_data = {$urandom, $urandom, $urandom, $urandom};
        step();
        app_rd_data_valid = 1'b0;
        step();
        check_eq("t5_no_rsp", rsp_valid, 3'b000);
        check_eq("t5_busy", busy, 1'b0);
        grant_q.delete();
        for (int p = 0; p < NP; p++) new_request(p);
        step();
        check_eq("t5_first_grant", (grant_q.size() > 0) ? grant_q[0] : -1, 0);
        drain();

        // Long randomized run with flickering calibration and back-pressure.
        n_done = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) init_calib_complete = ~init_calib_complete;
            drive_random(1'b0, 1'b0);
            step();
        end
        drain();
        check_eq("final_queue_empty", exp_q.size(), 0);
        check_eq("random_activity", n_done > 100, 1'b1);
        finish_report();
    end

endmodule

// File: doc/ddr3_port_arbiter.md
DDR3_PORT_ARBITER -- requirements
Module: ddr3_port_arbiter

Interface
REQ-001 The block SHALL use one clock, clk, and reset sys_rst, which is synchronous and active-high.
REQ-002 Parameter NUM_PORTS, 3, number of requesters (CPU ROM, PPU VRAM, APU).
REQ-003 Parameter ADDR_W, 27, MIG app address width.
REQ-004 Parameter DATA_W, 128, MIG app data width, one burst of 8 x 16-bit beats.
REQ-005 clk  in  1  MIG ui clock, all logic on its rising edge.
REQ-006 sys_rst  in  1  synchronous active-high reset.
REQ-007 init_calib_complete  in  1  MIG calibration done.
REQ-008 req_valid  in  NUM_PORTS  per-port request.
REQ-009 req_we  in  NUM_PORTS  per-port: 1 write, 0 read.
REQ-010 req_addr  in  NUM_PORTS x ADDR_W  per-port address.
REQ-011 req_wdata  in  NUM_PORTS x DATA_W  per-port write data.
REQ-012 req_wmask  in  NUM_PORTS x DATA_W/8  per-port byte mask, 1 = byte not written.
REQ-013 req_ready  out  NUM_PORTS  one-cycle accept pulse.
REQ-014 rsp_valid  out  NUM_PORTS  one-cycle read-data pulse to owning port.
REQ-015 rsp_rdata  out  DATA_W  shared read data, valid with rsp_valid.
REQ-016 app_en, app_cmd[2:0], app_addr[ADDR_W]  out  MIG command channel.
REQ-017 app_rdy  in  1  MIG command accept.
REQ-018 app_wdf_wren, app_wdf_end, app_wdf_data[DATA_W], app_wdf_mask[DATA_W/8]  out  MIG write-data channel.
REQ-019 app_wdf_rdy  in  1  MIG write-data accept.
REQ-020 app_rd_data[DATA_W], app_rd_data_valid  in  MIG read return.
REQ-021 busy  out  1  high whenever state is not IDLE.

Function
REQ-022 FSM states SHALL be IDLE, WDATA, CMD, RWAIT; one transaction in flight at most.
REQ-023 IDLE: if init_calib_complete=1 and any req_valid, grant round-robin starting at last_grant+1 (mod NUM_PORTS), pulse req_ready[g] that cycle, latch we/addr/wdata/wmask/owner, set last_grant=g; next state WDATA if write, else CMD.
REQ-024 init_calib_complete=0 SHALL block new grants only; an in-flight transaction completes.
REQ-025 WDATA: app_wdf_wren=app_wdf_end=1 with latched data/mask, held until app_wdf_rdy=1 sampled, then CMD.
REQ-026 CMD: app_en=1, app_cmd=3'b000 write / 3'b001 read, app_addr=latched addr with bits [2:0] forced 0, held stable until app_rdy=1 sampled; write -> IDLE, read -> RWAIT.
REQ-027 RWAIT: on app_rd_data_valid=1, register app_rd_data into rsp_rdata and pulse rsp_valid[owner] the following cycle; -> IDLE.
REQ-028 app_rd_data_valid outside RWAIT SHALL be ignored.
REQ-029 req_ready SHALL be 0 outside IDLE; a port may drop req_valid before acceptance without effect.
REQ-030 Minimum spacing: write 3 cycles (IDLE, WDATA, CMD), read 3 cycles plus MIG latency; next grant possible the cycle after returning to IDLE.

Reset
REQ-031 On sys_rst: state IDLE, last_grant=NUM_PORTS-1 (port 0 first), all outputs 0, latched fields 0.
REQ-032 Reset mid-transaction SHALL abandon it: app_en/app_wdf_wren low the cycle after reset, no rsp_valid for the abandoned read.

Structure
REQ-033 Package ddr3_arb_pkg SHALL hold the state enum and CMD_WRITE=3'b000, CMD_READ=3'b001.
REQ-034 Sub-module rr_arbiter SHALL be combinational: request vector + last_grant in, one-hot grant + index out.

Verification
REQ-035 Port 1 read 0x0000123 with app_rdy=1 -> app_addr=0x0000120, app_cmd=001; app_rd_data_valid with 0xA5.. -> rsp_valid[1] one cycle later, rsp_rdata=0xA5...
REQ-036 All three ports request continuously from reset -> grants 0,1,2,0,1,2; no port granted twice in a row.
REQ-037 Port 2 write with app_wdf_rdy low 4 cycles, then app_rdy low 2 cycles -> wren held 5 cycles, app_en held 3 cycles, signals stable throughout.
REQ-038 init_calib_complete=0 with req_valid=3'b111 -> no req_ready for 20 cycles; grant to port 0 the cycle calibration rises.
REQ-039 sys_rst asserted in RWAIT, then stray app_rd_data_valid -> no rsp_valid, busy=0, next grant to port 0.
